// File: rtl/rx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rx_sequencer                                                  |
// | Purpose  : Deframes one start/data/stop serial frame using mid-bit       |
// |            sampling, with a valid/read handshake to the consumer.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rx_sequencer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_detected,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy,
  output logic                 shift_strobe
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] C_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] C_FULL = TW'(CLKS_PER_BIT);
  localparam logic [BW-1:0] C_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    LOAD  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic [DATA_BITS-1:0]   w_shift_in;
  logic                   w_strobe;

  assign w_strobe = (timer_q == C_HALF);

  // A one-bit frame has no upper slice to shift down.
  if (DATA_BITS == 1) begin : g_shift_one
    assign w_shift_in = serial_in;
  end else begin : g_shift_multi
    assign w_shift_in = {serial_in, shift_q[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    valid_d      = valid_q;
    ferr_d       = ferr_q;
    ovr_d        = ovr_q;
    shift_strobe = 1'b0;

    // Wrapping to 1 (not 0) keeps strobes exactly CLKS_PER_BIT apart.
    if (state_q == START || state_q == DATA || state_q == STOP) begin
      timer_d = (timer_q == C_FULL) ? TW'(1) : timer_q + 1'b1;
    end

    if (data_read) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_detected) begin
          state_d = START;
          timer_d = '0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (w_strobe) begin
          if (!serial_in) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (w_strobe) begin
          shift_d      = w_shift_in;
          bit_cnt_d    = bit_cnt_q + 1'b1;
          shift_strobe = 1'b1;
          if (bit_cnt_q == C_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (w_strobe) begin
          if (serial_in) begin
            state_d = LOAD;
          end else begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      LOAD: begin
        // A coincident read loses to the load but still clears overrun.
        rx_data_d = shift_q;
        valid_d   = 1'b1;
        ovr_d     = valid_q & ~data_read;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data       = rx_data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign overrun_error = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rx_sequencer                                               |
// | Purpose  : Scoreboard bench for rx_sequencer with directed frames.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_rx_sequencer;

  localparam int C  = 10;
  localparam int H  = C / 2;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_detected = 1'b0;
  logic          serial_in = 1'b1;
  logic          data_read = 1'b0;
  logic [DB-1:0] rx_data;
  logic          data_valid, framing_error, overrun_error, busy, shift_strobe;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int data; int valid; int ferr; int ovr;
    int strobes; int first_s; int last_s; int end_cyc;
  } exp_t;

  exp_t sb[$];

  rx_sequencer #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clk(clk), .n_rst(n_rst), .start_detected(start_detected),
    .serial_in(serial_in), .data_read(data_read), .rx_data(rx_data),
    .data_valid(data_valid), .framing_error(framing_error),
    .overrun_error(overrun_error), .busy(busy), .shift_strobe(shift_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  // Monitor: every return of busy to 0 completes one frame and pops one entry.
  initial begin
    int   nstrb, first_s, last_s;
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0; nstrb = 0; first_s = -1; last_s = -1;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        busy_prev = 1'b0; nstrb = 0;
      end else begin
        if (busy && !busy_prev) begin
          nstrb = 0; first_s = -1; last_s = -1;
        end
        if (shift_strobe) begin
          if (nstrb == 0) first_s = cyc;
          last_s = cyc;
          nstrb++;
        end
        if (!busy && busy_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_frame_end", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rx_data",       int'(rx_data),       e.data);
            chk("data_valid",    int'(data_valid),    e.valid);
            chk("framing_error", int'(framing_error), e.ferr);
            chk("overrun_error", int'(overrun_error), e.ovr);
            chk("strobe_count",  nstrb,               e.strobes);
            chk("first_strobe",  first_s,             e.first_s);
            chk("last_strobe",   last_s,              e.last_s);
            chk("frame_end_cyc", cyc,                 e.end_cyc);
          end
        end
        busy_prev = busy;
      end
    end
  end

  task automatic send_frame(input logic [DB-1:0] d, input logic st, input logic sp,
                            input logic rd_load, input int e_data, input int e_v,
                            input int e_f, input int e_o);
    logic [DB+1:0] bits;
    exp_t e;
    int c0, last_k;
    bits = {sp, d, st};
    @(negedge clk);
    c0 = cyc + 1;
    e.data = e_data; e.valid = e_v; e.ferr = e_f; e.ovr = e_o;
    if (st) begin
      e.strobes = 0; e.first_s = -1; e.last_s = -1;
      e.end_cyc = c0 + H + 1;
      last_k = H + 2;
    end else begin
      e.strobes = DB; e.first_s = c0 + H + C; e.last_s = c0 + H + C * DB;
      if (sp) begin
        e.end_cyc = c0 + H + 2 + C * (DB + 1);
        last_k = H + 3 + C * (DB + 1);
      end else begin
        e.end_cyc = c0 + H + 1 + C * (DB + 1);
        last_k = H + 2 + C * (DB + 1);
      end
    end
    sb.push_back(e);
    start_detected = 1'b1;
    serial_in = bits[0];
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      start_detected = 1'b0;
      if ((k - 1) % C == 0 && (k - 1) / C <= DB + 1) serial_in = bits[(k - 1) / C];
      data_read = rd_load && (k == H + 2 + C * (DB + 1));
    end
    serial_in = 1'b1;
    data_read = 1'b0;
  endtask

  task automatic read_pulse(input int e_v, input int e_o);
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    chk("read_valid", int'(data_valid), e_v);
    chk("read_ovr",   int'(overrun_error), e_o);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_data"}, int'(rx_data), 0);
    chk({tag, "_valid"},   int'(data_valid), 0);
    chk({tag, "_ferr"},    int'(framing_error), 0);
    chk({tag, "_ovr"},     int'(overrun_error), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_strobe"},  int'(shift_strobe), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;

    // Abort a frame of ones during data bit 3.
    @(negedge clk);
    start_detected = 1'b1;
    serial_in = 1'b0;
    for (int k = 1; k <= H + 3 + 3 * C; k++) begin
      @(negedge clk);
      start_detected = 1'b0;
      if (k == C + 1) serial_in = 1'b1;
    end
    chk("abort_busy_before", int'(busy), 1);
    n_rst = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 0);  // stop bit low
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 0, 0);  // nominal, clears ferr
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1, 0, 0);  // false start
    read_pulse(0, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1, 0, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1, 0, 1);  // overrun
    read_pulse(0, 0);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1, 0, 0);
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 1, 0, 0);  // read during LOAD
    read_pulse(0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_sequencer.md
Name: rx_sequencer

Overview:
Serial-receive controller that sequences the lab's bit-timing and bit-count counters to deframe one start/data/stop frame.
- Generates mid-bit sample strobes from a wrap-around clock counter.
- Shifts data in LSB-first, checks the stop bit, and loads a holding register.
- Sits between the line synchronizer/start-edge detector and the consumer, with a valid/read handshake.

Parameters:
CLKS_PER_BIT, 10, clocks per serial bit; legal range 4..255.
DATA_BITS, 8, data bits per frame; legal range 1..16.

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
start_detected  input  1  one-cycle pulse on line falling edge; honoured only in IDLE
serial_in  input  1  synchronized serial line
data_read  input  1  consumer acknowledge; clears data_valid/overrun_error
rx_data  output  DATA_BITS  last good frame's data
data_valid  output  1  rx_data holds unread data
framing_error  output  1  last frame had stop bit = 0
overrun_error  output  1  a frame was loaded while data_valid was still set
busy  output  1  state != IDLE
shift_strobe  output  1  one-cycle pulse on each data-bit sample

Behaviour:
- Reset (n_rst=0): state IDLE; timer, bit_cnt and shift_reg = 0; all outputs = 0, including rx_data. Reset mid-frame aborts immediately with no partial load.
- Timer:
  - Width $clog2(CLKS_PER_BIT+1); HALF = CLKS_PER_BIT/2 (integer).
  - Cleared to 0 on entering START; increments every cycle in START/DATA/STOP.
  - Value CLKS_PER_BIT wraps to 1 on the next edge.
  - strobe = (timer == HALF), combinational; successive strobes are exactly CLKS_PER_BIT cycles apart.
- bit_cnt: width $clog2(DATA_BITS+1).
- States: IDLE, START, DATA, STOP, LOAD.
  - IDLE: start_detected=1 -> START; clear timer; clear framing_error. start_detected in any other state is ignored.
  - START: on strobe, serial_in=0 -> DATA with bit_cnt=0. serial_in=1 is a false start -> IDLE, no flags change.
  - DATA: on strobe, shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]} (LSB-first); bit_cnt++; shift_strobe=1 that cycle. Strobe that makes bit_cnt==DATA_BITS -> STOP.
  - STOP: on strobe, serial_in=1 -> LOAD. serial_in=0 -> framing_error<=1, IDLE; rx_data and data_valid unchanged.
  - LOAD: single cycle. rx_data<=shift_reg; data_valid<=1. overrun_error<=1 if data_valid=1 and data_read=0 in this cycle. Then -> IDLE.
- Handshake:
  - data_read=1 outside LOAD: data_valid<=0 and overrun_error<=0 on the next edge.
  - data_read coincident with LOAD: LOAD wins, data_valid stays 1, overrun_error<=0.
- Latency (edge E0 samples start_detected=1):
  - Start bit sampled at E(HALF+1).
  - Data bit k (0-based) sampled at E(HALF+1+CLKS_PER_BIT*(k+1)).
  - Stop bit sampled at E(HALF+1+CLKS_PER_BIT*(DATA_BITS+1)).
  - data_valid rises one edge after the stop-bit edge. Defaults: stop at E96, data_valid=1 after E97.
- busy=1 from the edge entering START until the edge returning to IDLE. A new start_detected is accepted in the first IDLE cycle after LOAD.

Test Plan:
1. Reset mid-frame: drop n_rst during DATA bit 3 -> all outputs 0 immediately, busy=0; frame restarts cleanly after release.
2. Nominal frame, defaults, byte 0xA5: line 0, then 1,0,1,0,0,1,0,1, then 1 -> 8 shift_strobe pulses at E16..E86; data_valid=1 after E97; rx_data=0xA5; framing_error=0.
3. False start: pulse start_detected, hold serial_in=1 -> IDLE after E6, busy=0, no flags, data_valid unchanged.
4. Framing error: send 0x5A with stop bit 0 -> framing_error=1, data_valid=0, rx_data still 0x00. Next valid start clears framing_error at its E0.
5. Overrun: 0x3C then 0xC3 with no data_read -> rx_data=0xC3, data_valid=1, overrun_error=1. A one-cycle data_read then gives data_valid=0 and overrun_error=0 on the next edge.
6. Read/load collision: data_read asserted exactly in the LOAD cycle of a second frame -> data_valid stays 1, overrun_error=0, rx_data = new byte.
